// File: rtl/bch_wrapper_encoder_mem.sv
// bch_wrapper_encoder_mem: serial systematic BCH parity encoder. It writes the
// parity to memory in the word layout that the decoder memory wrapper reads back.
// Optional build macro BCH_ENC_VERIFY_EN adds a read-back verify pass and the
// O_verify_err output.
module bch_wrapper_encoder_mem #(
  parameter int unsigned              C_DATA_BITS     = 7,
  parameter int unsigned              C_ECC_BITS      = 8,
  parameter logic [C_ECC_BITS-1:0]    C_GEN_POLY      = 8'hD1,
  parameter int unsigned              C_MEM_ADDR_SIZE = 10,
  parameter int unsigned              C_MEM_DATA_SIZE = 8,
  parameter int unsigned              C_MEM_ST_ADDR   = 0
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_start,
  input  logic [C_DATA_BITS-1:0]      I_data,
  input  logic [C_MEM_DATA_SIZE-1:0]  I_mem_data,
  output logic [C_MEM_ADDR_SIZE-1:0]  O_mem_addr,
  output logic [C_MEM_DATA_SIZE-1:0]  O_mem_data,
  output logic                        O_mem_we,
  output logic [C_ECC_BITS-1:0]       O_ecc,
  output logic                        O_busy,
  output logic                        O_done
`ifdef BCH_ENC_VERIFY_EN
  ,
  output logic                        O_verify_err
`endif
);

  // One extra word always, so the write count matches the decoder read count
  localparam int unsigned LP_MEM_WORDS = C_ECC_BITS / C_MEM_DATA_SIZE + 1;
  localparam int unsigned LP_PAD_W     = LP_MEM_WORDS * C_MEM_DATA_SIZE;
  localparam int unsigned LP_CNT_MAX   = (C_DATA_BITS > LP_MEM_WORDS + 1) ?
                                         C_DATA_BITS : LP_MEM_WORDS + 1;
  localparam int unsigned LP_CNT_W     = $clog2(LP_CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WRITE,
`ifdef BCH_ENC_VERIFY_EN
    ST_VERIFY,
`endif
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [C_ECC_BITS-1:0]       lfsr_q, lfsr_d, lfsr_step;
  logic [C_DATA_BITS-1:0]      shreg_q, shreg_d;
  logic [LP_CNT_W-1:0]         cnt_q, cnt_d, cnt_nx;
  logic [C_ECC_BITS-1:0]       ecc_d;
  logic [C_MEM_ADDR_SIZE-1:0]  addr_d;
  logic [C_MEM_DATA_SIZE-1:0]  data_d;
  logic                        we_d;
  logic                        done_d;
  logic                        fb;
`ifdef BCH_ENC_VERIFY_EN
  logic                        err_q, err_d;
  logic [LP_CNT_W-1:0]         cnt_prev;
`else
  logic                        unused_mem_data;
  assign unused_mem_data = ^I_mem_data;
`endif

  // Word k of the zero-padded parity; word 0 carries the LSBs
  function automatic logic [C_MEM_DATA_SIZE-1:0] ecc_word(
    input logic [C_ECC_BITS-1:0] e,
    input int unsigned           k
  );
    logic [LP_PAD_W-1:0] p;
    p = LP_PAD_W'(e);
    return p[k*C_MEM_DATA_SIZE +: C_MEM_DATA_SIZE];
  endfunction

  // Address of parity word k, wrapping at the address width
  function automatic logic [C_MEM_ADDR_SIZE-1:0] word_addr(input int unsigned k);
    return C_MEM_ADDR_SIZE'(C_MEM_ST_ADDR + k);
  endfunction

  assign cnt_nx = cnt_q + LP_CNT_W'(1);

  // One LFSR division step on the current message MSB
  always_comb begin
    fb        = 1'b0;
    lfsr_step = '0;
    fb        = shreg_q[C_DATA_BITS-1] ^ lfsr_q[C_ECC_BITS-1];
    lfsr_step = (lfsr_q << 1) ^ (fb ? C_GEN_POLY : '0);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ecc_d   = O_ecc;
    addr_d  = O_mem_addr;
    data_d  = O_mem_data;
    we_d    = 1'b0;
    done_d  = 1'b0;
`ifdef BCH_ENC_VERIFY_EN
    err_d    = err_q;
    cnt_prev = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          shreg_d = I_data;
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef BCH_ENC_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end

      ST_SHIFT: begin
        lfsr_d  = lfsr_step;
        shreg_d = shreg_q << 1;
        if (cnt_q == LP_CNT_W'(C_DATA_BITS - 1)) begin
          ecc_d   = lfsr_step;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = word_addr(0);
          data_d  = ecc_word(lfsr_step, 0);
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_nx;
        end
      end

      ST_WRITE: begin
        if (cnt_q == LP_CNT_W'(LP_MEM_WORDS - 1)) begin
          cnt_d   = '0;
`ifdef BCH_ENC_VERIFY_EN
          addr_d  = word_addr(0);
          state_d = ST_VERIFY;
`else
          done_d  = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          cnt_d  = cnt_nx;
          we_d   = 1'b1;
          addr_d = word_addr(32'(cnt_nx));
          data_d = ecc_word(O_ecc, 32'(cnt_nx));
        end
      end

`ifdef BCH_ENC_VERIFY_EN
      // Read data lags its address by one cycle, so compare word cnt-1
      ST_VERIFY: begin
        if (cnt_q != '0) begin
          cnt_prev = cnt_q - LP_CNT_W'(1);
          if (I_mem_data != ecc_word(O_ecc, 32'(cnt_prev))) begin
            err_d = 1'b1;
          end
        end
        if (cnt_q == LP_CNT_W'(LP_MEM_WORDS)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_nx;
          if (cnt_nx < LP_CNT_W'(LP_MEM_WORDS)) begin
            addr_d = word_addr(32'(cnt_nx));
          end
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      O_ecc      <= '0;
      O_mem_addr <= '0;
      O_mem_data <= '0;
      O_mem_we   <= 1'b0;
      O_busy     <= 1'b0;
      O_done     <= 1'b0;
`ifdef BCH_ENC_VERIFY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      O_ecc      <= ecc_d;
      O_mem_addr <= addr_d;
      O_mem_data <= data_d;
      O_mem_we   <= we_d;
      O_busy     <= (state_d != ST_IDLE);
      O_done     <= done_d;
`ifdef BCH_ENC_VERIFY_EN
      err_q      <= err_d;
`endif
    end
  end

`ifdef BCH_ENC_VERIFY_EN
  assign O_verify_err = err_q;
`endif

endmodule

// File: tb/tb_bch_wrapper_encoder_mem.sv
// Bench for bch_wrapper_encoder_mem: directed and random encodes checked against
// a polynomial long-division parity model and a memory write log.
`timescale 1ns/1ps
module tb_bch_wrapper_encoder_mem;

  localparam int LP_WORDS = 2;
`ifdef BCH_ENC_VERIFY_EN
  localparam int LP_LAT = 7 + LP_WORDS + 1 + LP_WORDS + 1;
`else
  localparam int LP_LAT = 7 + LP_WORDS + 1;
`endif

  logic       I_clk = 1'b0;
  logic       I_rst = 1'b1;
  logic       I_start = 1'b0;
  logic [6:0] I_data = '0;
  logic [7:0] I_mem_data;
  logic [9:0] O_mem_addr;
  logic [7:0] O_mem_data;
  logic       O_mem_we;
  logic [7:0] O_ecc;
  logic       O_busy;
  logic       O_done;
`ifdef BCH_ENC_VERIFY_EN
  logic       O_verify_err;
`endif

  int checks = 0;
  int failures = 0;
  logic [17:0] wlog[$];
  logic [7:0]  mem [0:1023];
  logic        corrupt = 1'b0;

  always #5 I_clk = ~I_clk;

  bch_wrapper_encoder_mem dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_data(I_data),
    .I_mem_data(I_mem_data), .O_mem_addr(O_mem_addr), .O_mem_data(O_mem_data),
    .O_mem_we(O_mem_we), .O_ecc(O_ecc), .O_busy(O_busy), .O_done(O_done)
`ifdef BCH_ENC_VERIFY_EN
    , .O_verify_err(O_verify_err)
`endif
  );

  // Synchronous memory; optional fault makes address 1 read back as 8'h01
  always @(posedge I_clk) begin
    if (O_mem_we) mem[O_mem_addr] <= O_mem_data;
    I_mem_data <= (corrupt && O_mem_addr == 10'd1) ? 8'h01 : mem[O_mem_addr];
  end

  always @(posedge I_clk) begin
    if (O_mem_we) wlog.push_back({O_mem_addr, O_mem_data});
  end

  // Remainder of d(x)*x^8 divided by g(x) = x^8 + 0xD1
  function automatic logic [7:0] ref_parity(input logic [6:0] d);
    logic [14:0] r;
    logic [14:0] g;
    r = {d, 8'h00};
    g = 15'h1D1;
    for (int i = 14; i >= 8; i--)
      if (r[i]) r = r ^ (g << (i - 8));
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge I_clk);
    #1;
  endtask

  // Start at cycle 0, optionally pulse a second start during SHIFT, check all outputs
  task automatic encode(input logic [6:0] d, input bit glitch, input string tag);
    logic [7:0] exp;
    logic [15:0] exp_pad;
    int n;
    exp = ref_parity(d);
    exp_pad = {8'h00, exp};
    wlog.delete();
    check({tag, "_idle_busy"}, 32'(O_busy), 32'd0);
    I_start = 1'b1;
    I_data = d;
    cyc();
    I_start = 1'b0;
    n = 1;
    check({tag, "_busy"}, 32'(O_busy), 32'd1);
    while (!O_done && n < 40) begin
      cyc();
      n++;
      if (glitch && n == 3) begin
        I_start = 1'b1;
        I_data = ~d;
      end else begin
        I_start = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(LP_LAT));
    check({tag, "_ecc"}, 32'(O_ecc), 32'(exp));
    check({tag, "_nwrites"}, 32'(wlog.size()), 32'(LP_WORDS));
    for (int k = 0; k < LP_WORDS && k < wlog.size(); k++) begin
      check({tag, "_waddr"}, 32'(wlog[k][17:8]), 32'(k));
      check({tag, "_wdata"}, 32'(wlog[k][7:0]), 32'(exp_pad[k*8 +: 8]));
    end
    check({tag, "_we_done"}, 32'(O_mem_we), 32'd0);
    cyc();
    check({tag, "_done_pulse"}, 32'(O_done), 32'd0);
    check({tag, "_addr_hold"}, 32'(O_mem_addr), 32'(LP_WORDS - 1));
  endtask

  initial begin
    int n;
    int seen;
    // Reset state
    cyc(); cyc(); cyc();
    check("rst_addr", 32'(O_mem_addr), 32'd0);
    check("rst_data", 32'(O_mem_data), 32'd0);
    check("rst_we",   32'(O_mem_we),   32'd0);
    check("rst_ecc",  32'(O_ecc),      32'd0);
    check("rst_busy", 32'(O_busy),     32'd0);
    check("rst_done", 32'(O_done),     32'd0);
    I_rst = 1'b0;
    cyc();

    // Directed vectors; each encode starts in the cycle after the previous done
    encode(7'h01, 1'b0, "d01");
    check("d01_const", 32'(O_ecc), 32'h0D1);
    encode(7'h03, 1'b0, "d03");
    check("d03_const", 32'(O_ecc), 32'h0A2);
    encode(7'h00, 1'b0, "d00");
    check("d00_const", 32'(O_ecc), 32'h000);
    encode(7'h7F, 1'b0, "d7f");

    // Start during SHIFT ignored, then back-to-back start accepted
    encode(7'h2A, 1'b1, "ignore");
    encode(7'h55, 1'b0, "b2b");

    // Random messages
    for (int i = 0; i < 10; i++) begin
      encode(7'($urandom), 1'b0, "rand");
    end

    // Reset in the first WRITE cycle aborts the encode
    wlog.delete();
    I_start = 1'b1;
    I_data = 7'h01;
    cyc();
    I_start = 1'b0;
    n = 1;
    while (!O_mem_we && n < 30) begin
      cyc();
      n++;
    end
    check("abort_first_write_cycle", 32'(n), 32'd8);
    I_rst = 1'b1;
    cyc();
    check("abort_we",   32'(O_mem_we), 32'd0);
    check("abort_busy", 32'(O_busy),   32'd0);
    check("abort_ecc",  32'(O_ecc),    32'd0);
    I_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (O_done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_nwrites", 32'(wlog.size()), 32'd1);

    // Recovery after abort
    encode(7'h03, 1'b0, "recover");

`ifdef BCH_ENC_VERIFY_EN
    corrupt = 1'b1;
    encode(7'h01, 1'b0, "vbad");
    check("verify_err_corrupt", 32'(O_verify_err), 32'd1);
    corrupt = 1'b0;
    encode(7'h01, 1'b0, "vgood");
    check("verify_err_clean", 32'(O_verify_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
